// File: rtl/xor_share_ctrl.sv
// Round-robin controller sharing one external WIDTH-bit XOR datapath between
// N_REQ requesters; one operation in flight, response tagged with requester ID.
module xor_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]         xor_a,
  output logic [WIDTH-1:0]         xor_b,
  input  logic [WIDTH-1:0]         xor_y,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_cur_id;
  logic [ID_W-1:0]   r_rsp_id;
  logic [WIDTH-1:0]  r_xor_a;
  logic [WIDTH-1:0]  r_xor_b;
  logic [WIDTH-1:0]  r_rsp_data;
  logic              r_rsp_valid;
  logic [CNT_W-1:0]  r_op_count;

  logic [ID_W-1:0]   w_grant;
  logic [ID_W-1:0]   w_ptr_next;
  logic              w_any;
  int                w_idx;
  logic [WIDTH-1:0]  w_a_arr [N_REQ];
  logic [WIDTH-1:0]  w_b_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_a_arr[gi]   = req_a[gi*WIDTH +: WIDTH];
      assign w_b_arr[gi]   = req_b[gi*WIDTH +: WIDTH];
      // rst_n gating keeps the accept strobe low while reset is held.
      assign req_ready[gi] = rst_n && (r_state == IDLE) && w_any &&
                             (w_grant == ID_W'(gi));
    end
  endgenerate

  // Scan offsets from farthest to nearest so the closest valid requester
  // at or after r_ptr is the one left in w_grant.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_idx   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (req_valid[w_idx]) begin
        w_grant = ID_W'(w_idx);
        w_any   = 1'b1;
      end
    end
  end

  assign w_ptr_next = (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cur_id    <= '0;
      r_rsp_id    <= '0;
      r_xor_a     <= '0;
      r_xor_b     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_xor_a  <= w_a_arr[w_grant];
            r_xor_b  <= w_b_arr[w_grant];
            r_cur_id <= w_grant;
            r_ptr    <= w_ptr_next;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data  <= xor_y;
          r_rsp_id    <= r_cur_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_op_count != '1) r_op_count <= r_op_count + CNT_W'(1);
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign xor_a     = r_xor_a;
  assign xor_b     = r_xor_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign op_count  = r_op_count;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_xor_share_ctrl.sv
// Self-checking bench for xor_share_ctrl: random and directed transactions
// compared against a round-robin/XOR reference model kept in the bench.
module tb_xor_share_ctrl;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IDW = 2;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   xor_a, xor_b, xor_y;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [IDW-1:0] rsp_id;
  logic           rsp_ready = 1'b0;
  logic           busy;
  logic [CW-1:0]  op_count;

  int errors = 0;
  int checks = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int cyc = 0;
  int last_accept = 0;
  int last_grant = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The shared XOR datapath that the controller drives.
  assign xor_y = xor_a ^ xor_b;

  xor_share_ctrl #(.N_REQ(N), .WIDTH(W), .ID_W(IDW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .xor_a(xor_a), .xor_b(xor_b),
    .xor_y(xor_y), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy), .op_count(op_count)
  );

  // Reference grant: first valid requester at or after m_ptr, wrapping.
  function automatic int exp_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE to response handshake, checked at each stage.
  task automatic do_xact(input logic [N-1:0] v, input logic [N*W-1:0] a,
                         input logic [N*W-1:0] b, input int stall);
    int g;
    logic [N-1:0] rdy_exp;
    logic [W-1:0] a_exp, b_exp, y_exp;
    req_valid = v; req_a = a; req_b = b; rsp_ready = (stall == 0);
    #1;
    g = exp_grant(v);
    rdy_exp = '0;
    rdy_exp[g] = 1'b1;
    a_exp = a[g*W +: W];
    b_exp = b[g*W +: W];
    y_exp = a_exp ^ b_exp;
    checks++;
    if (req_ready !== rdy_exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL grant: req_ready=%b busy=%b want req_ready=%b busy=0", req_ready, busy, rdy_exp);
    end
    step();
    last_accept = cyc;
    last_grant = g;
    m_ptr = (g + 1) % N;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    #1;
    checks++;
    if (xor_a !== a_exp || xor_b !== b_exp || busy !== 1'b1 || req_ready !== '0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL exec: xor_a=%h xor_b=%h busy=%b rdy=%b rv=%b want %h %h 1 0000 0", xor_a, xor_b, busy, req_ready, rsp_valid, a_exp, b_exp);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== y_exp || rsp_id !== IDW'(g)) begin
      errors++;
      $display("FAIL resp: valid=%b data=%h id=%0d want 1 %h %0d", rsp_valid, rsp_data, rsp_id, y_exp, g);
    end
    for (int s = 0; s < stall; s++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== y_exp || rsp_id !== IDW'(g) || req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold: valid=%b data=%h id=%0d rdy=%b busy=%b want 1 %h %0d 0000 1", rsp_valid, rsp_data, rsp_id, req_ready, busy, y_exp, g);
      end
    end
    rsp_ready = 1'b1;
    step();
    if (m_cnt < 65535) m_cnt++;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL done: valid=%b busy=%b op_count=%0d want 0 0 %0d", rsp_valid, busy, op_count, m_cnt);
    end
    $display("xact: grant=%0d a=%h b=%h y=%h stall=%0d cyc=%0d", g, a_exp, b_exp, y_exp, stall, last_accept);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    m_ptr = 0; m_cnt = 0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_valid = '1; req_a = '1; req_b = '0;
    rst_n = 1'b0;
    step();
    checks++;
    if (req_ready !== '0 || xor_a !== '0 || xor_b !== '0 || rsp_valid !== 1'b0 ||
        rsp_data !== '0 || rsp_id !== '0 || op_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b xa=%h xb=%h rv=%b rd=%h id=%0d cnt=%0d busy=%b want all zero", req_ready, xor_a, xor_b, rsp_valid, rsp_data, rsp_id, op_count, busy);
    end
    req_valid = '0;
    apply_reset();
  endtask

  task automatic test_single();
    logic [N*W-1:0] a, b;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    a[7:0] = 8'h0F; b[7:0] = 8'hFF;
    do_xact(4'b0001, a, b, 0);
    req_valid = '0;
  endtask

  task automatic test_truth();
    logic [7:0] av [4];
    logic [7:0] bv [4];
    logic [N*W-1:0] a, b;
    av = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    bv = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      a[2*W +: W] = av[i]; b[2*W +: W] = bv[i];
      do_xact(4'b0100, a, b, 0);
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    int prev;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      prev = last_accept;
      do_xact(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 0);
      checks++;
      if (last_grant !== k % N || (k > 0 && last_accept - prev != 3)) begin
        errors++;
        $display("FAIL b2b: grant=%0d spacing=%0d want %0d 3", last_grant, last_accept - prev, k % N);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_xact(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 5);
    do_xact(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1010; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    rsp_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_exec: busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || xor_a !== '0 || xor_b !== '0 || rsp_valid !== 1'b0 ||
        rsp_data !== '0 || rsp_id !== '0 || op_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b xa=%h xb=%h rv=%b rd=%h id=%0d cnt=%0d busy=%b want all zero", req_ready, xor_a, xor_b, rsp_valid, rsp_data, rsp_id, op_count, busy);
    end
    m_ptr = 0; m_cnt = 0;
    step();
    rst_n = 1'b1;
    #1;
    do_xact(4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    checks++;
    if (last_grant != 1) begin
      errors++;
      $display("FAIL post_reset_grant: got %0d want 1", last_grant);
    end
    req_valid = '0;
  endtask

  task automatic test_withdraw();
    int cnt0;
    req_valid = 4'b0001; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    rsp_ready = 1'b0;
    m_ptr = exp_grant(4'b0001) + 1;
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0010;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL wd_resp: rv=%b rdy=%b want 1 0000", rsp_valid, req_ready);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    if (m_cnt < 65535) m_cnt++;
    cnt0 = m_cnt;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0 || op_count !== CW'(cnt0)) begin
        errors++;
        $display("FAIL withdraw: busy=%b rv=%b rdy=%b cnt=%0d want 0 0 0000 %0d", busy, rsp_valid, req_ready, op_count, cnt0);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int i = 0; i < 24; i++) begin
      v = N'($urandom_range(1, 15));
      do_xact(v, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_truth();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
